// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 raster timing, sync polarities
// and total-period helpers shared by the VGA timing blocks.
package vga_pkg;

  localparam int CW_DEF       = 10;
  localparam int CLK_DIV_DEF  = 2;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam bit HS_POL_DEF   = 1'b0;
  localparam bit VS_POL_DEF   = 1'b0;

  function automatic int h_total(
    input int act,
    input int fp,
    input int sync,
    input int bp
  );
    return act + fp + sync + bp;
  endfunction

  function automatic int v_total(
    input int act,
    input int fp,
    input int sync,
    input int bp
  );
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_ctrl_mod_counter.sv
// mod_counter: N-bit modulo-MOD counter with increment enable,
// synchronous active-low reset and a combinational wrap flag.
module mod_counter #(
  parameter int N   = 4,
  parameter int MOD = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [N-1:0] cnt,
  output logic         wrap
);

  localparam logic [N-1:0] LAST = N'(MOD - 1);

  logic [N-1:0] r_cnt;

  assign wrap = inc && (r_cnt == LAST);
  assign cnt  = r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (wrap) begin
      r_cnt <= '0;
    end else if (inc) begin
      r_cnt <= r_cnt + N'(1);
    end
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: pixel-clock divider, h/v raster counters and
// registered sync / video / coordinate / strobe decode.
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int CW       = CW_DEF,
  parameter int CLK_DIV  = CLK_DIV_DEF,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit HS_POL   = HS_POL_DEF,
  parameter bit VS_POL   = VS_POL_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  output logic          pix_tick,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int HT = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int VT = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  localparam logic [CW-1:0] HA  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] HS0 = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS1 = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VA  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] VS0 = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS1 = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] w_div;
  logic          w_div_wrap;
  logic [CW-1:0] w_hcnt;
  logic          w_h_wrap;
  logic [CW-1:0] w_vcnt;
  logic          w_v_wrap;

  logic [CW-1:0] r_x;
  logic [CW-1:0] r_y;
  logic          r_vid;
  logic          r_hs;
  logic          r_vs;
  logic          r_hw;
  logic          r_fw;
  logic          r_ls;
  logic          r_fs;

  mod_counter #(.N(DW), .MOD(CLK_DIV)) u_div (
    .clk  (clk),
    .rst  (rst),
    .inc  (ena),
    .cnt  (w_div),
    .wrap (w_div_wrap)
  );

  // Reset must hold pix_tick low even when CLK_DIV=1.
  assign pix_tick = rst && w_div_wrap && (w_div == DIV_LAST);

  mod_counter #(.N(CW), .MOD(HT)) u_hcnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (pix_tick),
    .cnt  (w_hcnt),
    .wrap (w_h_wrap)
  );

  mod_counter #(.N(CW), .MOD(VT)) u_vcnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (w_h_wrap),
    .cnt  (w_vcnt),
    .wrap (w_v_wrap)
  );

  // Strobes pass through two stages so they land on the first
  // cycle the registered x/y show the wrapped position.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_x   <= '0;
      r_y   <= '0;
      r_vid <= 1'b0;
      r_hs  <= ~HS_POL;
      r_vs  <= ~VS_POL;
      r_hw  <= 1'b0;
      r_fw  <= 1'b0;
      r_ls  <= 1'b0;
      r_fs  <= 1'b0;
    end else begin
      r_x   <= w_hcnt;
      r_y   <= w_vcnt;
      r_vid <= (w_hcnt < HA) && (w_vcnt < VA);
      r_hs  <= (w_hcnt >= HS0 && w_hcnt < HS1) ?
               HS_POL : ~HS_POL;
      r_vs  <= (w_vcnt >= VS0 && w_vcnt < VS1) ?
               VS_POL : ~VS_POL;
      r_hw  <= w_h_wrap;
      r_fw  <= w_v_wrap;
      r_ls  <= r_hw;
      r_fs  <= r_fw;
    end
  end

  assign x           = r_x;
  assign y           = r_y;
  assign video_on    = r_vid;
  assign hsync       = r_hs;
  assign vsync       = r_vs;
  assign line_start  = r_ls;
  assign frame_start = r_fs;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: directed checks of the VGA raster timing
// at default 640x480 timing and at a tiny 8x6 raster.
module tb_vga_timing_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, ena, rst_s, ena_s;
  logic       pix, hs, vs, vid, ls, fs;
  logic [9:0] x, y;
  logic       pix_s, hs_s, vs_s, vid_s, ls_s, fs_s;
  logic [9:0] x_s, y_s;

  int n_vec = 0;
  int n_err = 0;

  vga_timing_ctrl u_dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .pix_tick    (pix),
    .hsync       (hs),
    .vsync       (vs),
    .video_on    (vid),
    .x           (x),
    .y           (y),
    .line_start  (ls),
    .frame_start (fs)
  );

  vga_timing_ctrl #(
    .CW(10), .CLK_DIV(1),
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_sm (
    .clk         (clk),
    .rst         (rst_s),
    .ena         (ena_s),
    .pix_tick    (pix_s),
    .hsync       (hs_s),
    .vsync       (vs_s),
    .video_on    (vid_s),
    .x           (x_s),
    .y           (y_s),
    .line_start  (ls_s),
    .frame_start (fs_s)
  );

  task automatic test_reset();
    logic [25:0] got, exp;
    rst = 1'b0;
    ena = 1'b1;
    repeat (3) @(negedge clk);
    got = {x, y, vid, hs, vs, pix, ls, fs};
    exp = {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 3'b000};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL reset_state: got %h want %h", got, exp);
    end
    rst = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      n_vec++;
      if (pix !== 1'(k % 2)) begin
        n_err++;
        $display("FAIL pix_toggle k=%0d: got %b want %b",
                 k, pix, 1'(k % 2));
      end
      if (k == 1) begin
        n_vec++;
        if ({vid, x, y} !== {1'b1, 10'd0, 10'd0}) begin
          n_err++;
          $display("FAIL first_pixel: vid=%b x=%0d y=%0d want 1,0,0",
                   vid, x, y);
        end
      end
    end
  endtask

  task automatic test_line();
    int t, cyc, ticks, vticks, hticks, hmin, hmax, vs_bad;
    t = 0;
    while (ls !== 1'b1 && t < 4000) begin
      @(negedge clk);
      t++;
    end
    n_vec++;
    if (ls !== 1'b1) begin
      n_err++;
      $display("FAIL line_wait: got timeout want line_start");
      return;
    end
    n_vec++;
    if (x !== 10'd0) begin
      n_err++;
      $display("FAIL line_start_x: got %0d want 0", x);
    end
    cyc = 0; ticks = 0; vticks = 0; hticks = 0;
    hmin = 1023; hmax = 0; vs_bad = 0;
    do begin
      if (pix === 1'b1) begin
        ticks++;
        if (vid === 1'b1) vticks++;
        if (hs === 1'b0) begin
          hticks++;
          if (int'(x) < hmin) hmin = int'(x);
          if (int'(x) > hmax) hmax = int'(x);
        end
      end
      if (vs !== 1'b1) vs_bad++;
      @(negedge clk);
      cyc++;
    end while (ls !== 1'b1 && cyc < 4000);
    n_vec++;
    if (cyc !== 1600) begin
      n_err++;
      $display("FAIL line_clks: got %0d want 1600", cyc);
    end
    n_vec++;
    if (ticks !== 800) begin
      n_err++;
      $display("FAIL line_ticks: got %0d want 800", ticks);
    end
    n_vec++;
    if (vticks !== 640) begin
      n_err++;
      $display("FAIL video_ticks: got %0d want 640", vticks);
    end
    n_vec++;
    if ({hticks, hmin, hmax} !== {32'd96, 32'd656, 32'd751}) begin
      n_err++;
      $display("FAIL hsync_window: got n=%0d %0d..%0d want 96 656..751",
               hticks, hmin, hmax);
    end
    n_vec++;
    if (vs_bad !== 0) begin
      n_err++;
      $display("FAIL vsync_idle: got %0d active clks want 0", vs_bad);
    end
  endtask

  task automatic test_freeze();
    int t;
    logic [23:0] snap, got;
    t = 0;
    while (!(x === 10'd100 && pix === 1'b1) && t < 4000) begin
      @(negedge clk);
      t++;
    end
    n_vec++;
    if (x !== 10'd100) begin
      n_err++;
      $display("FAIL freeze_wait: got x=%0d want 100", x);
      return;
    end
    ena = 1'b0;
    #1;
    n_vec++;
    if (pix !== 1'b0) begin
      n_err++;
      $display("FAIL freeze_pix: got %b want 0", pix);
    end
    snap = {3'b000, x, y, vid, hs, vs};
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      got = {pix, ls, fs, x, y, vid, hs, vs};
      n_vec++;
      if (got !== snap) begin
        n_err++;
        $display("FAIL freeze_hold k=%0d: got %h want %h", k, got, snap);
      end
    end
    ena = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_vec++;
      if (x !== 10'(100 + k / 2)) begin
        n_err++;
        $display("FAIL resume_x k=%0d: got %0d want %0d",
                 k, x, 100 + k / 2);
      end
    end
  endtask

  task automatic test_mid_reset();
    int t, c, fs_seen;
    logic [25:0] got, exp;
    t = 0;
    while (x !== 10'd300 && t < 4000) begin
      @(negedge clk);
      t++;
    end
    rst = 1'b0;
    @(negedge clk);
    got = {x, y, vid, hs, vs, pix, ls, fs};
    exp = {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 3'b000};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL mid_reset_state: got %h want %h", got, exp);
    end
    rst = 1'b1;
    c = 0;
    fs_seen = 0;
    do begin
      @(negedge clk);
      c++;
      if (fs === 1'b1) fs_seen++;
      if (c == 1) begin
        n_vec++;
        if ({vid, pix, x, y} !== {2'b11, 10'd0, 10'd0}) begin
          n_err++;
          $display("FAIL restart_origin: got vid=%b pix=%b x=%0d y=%0d",
                   vid, pix, x, y);
        end
      end
    end while (ls !== 1'b1 && c < 2000);
    n_vec++;
    if ({c, x, y} !== {32'd1601, 10'd0, 10'd1}) begin
      n_err++;
      $display("FAIL restart_line: got c=%0d x=%0d y=%0d want 1601,0,1",
               c, x, y);
    end
    n_vec++;
    if (fs_seen !== 0) begin
      n_err++;
      $display("FAIL restart_no_frame: got %0d want 0", fs_seen);
    end
  endtask

  task automatic test_small_wrap();
    logic [24:0] got, exp;
    int xe, ye;
    rst_s = 1'b0;
    ena_s = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({x_s, y_s, vid_s, hs_s, vs_s, pix_s, ls_s, fs_s} !== 26'd0) begin
      n_err++;
      $display("FAIL small_reset: got x=%0d y=%0d hs=%b vs=%b pix=%b",
               x_s, y_s, hs_s, vs_s, pix_s);
    end
    rst_s = 1'b1;
    for (int k = 1; k <= 110; k++) begin
      @(negedge clk);
      xe  = (k - 1) % 8;
      ye  = ((k - 1) / 8) % 6;
      exp = {10'(xe), 10'(ye),
             (xe < 4 && ye < 3),
             (xe == 5 || xe == 6),
             (ye == 4),
             (k > 1 && (k - 1) % 8 == 0),
             (k > 1 && (k - 1) % 48 == 0)};
      got = {x_s, y_s, vid_s, hs_s, vs_s, ls_s, fs_s};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL small_raster k=%0d: got %h want %h", k, got, exp);
      end
    end
  endtask

  initial begin
    rst   = 1'b0;
    ena   = 1'b1;
    rst_s = 1'b0;
    ena_s = 1'b1;
    test_reset();
    test_small_wrap();
    test_line();
    test_freeze();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
